// File: rtl/x_tx_fifo.sv
// x_tx_fifo: first-word-fall-through byte buffer between the x_driver response
// output and the x_uart_tx input. It absorbs driver bursts while the UART
// serialises one byte at a time. It tracks current and peak occupancy and
// supports a synchronous flush.
module x_tx_fifo #(
  parameter int unsigned p_width = 8,
  parameter int unsigned p_depth = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [p_width-1:0]         i_data,
  output logic                       o_accept,
  output logic                       o_valid,
  output logic [p_width-1:0]         o_data,
  input  logic                       i_accept,
  output logic [$clog2(p_depth):0]   o_level,
  output logic [$clog2(p_depth):0]   o_max_level
);

  localparam int unsigned c_pw = $clog2(p_depth);
  localparam int unsigned c_lw = c_pw + 1;
  localparam logic [c_lw-1:0] c_full = c_lw'(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [c_pw-1:0]    wr_ptr;
  logic [c_pw-1:0]    rd_ptr;
  logic [c_lw-1:0]    level;
  logic [c_lw-1:0]    level_next;
  logic [c_lw-1:0]    max_level;
  logic               accept_q;
  logic               not_empty;
  logic               push;
  logic               pop;

  // Full/empty come from the occupancy count, never from a pointer compare.
  // accept_q is the registered "not full" status. A flush in progress blocks
  // both sides, so no transfer is ever lost mid-flush.
  assign not_empty = (level != '0);
  assign push      = i_valid & accept_q & ~i_flush;
  assign pop       = not_empty & i_accept & ~i_flush;

  // Next occupancy: a flush clears it; a simultaneous push and pop leave it unchanged.
  always_comb begin
    level_next = level;
    if (i_flush) begin
      level_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_next = level + 1'b1;
        2'b01:   level_next = level - 1'b1;
        default: level_next = level;
      endcase
    end
  end

  // Storage write port; the array is intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy, peak occupancy and the registered accept status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level     <= '0;
      max_level <= '0;
      accept_q  <= 1'b0;
    end else begin
      level    <= level_next;
      accept_q <= (level_next != c_full);
      if (i_flush) begin
        max_level <= '0;
      end else if (level_next > max_level) begin
        max_level <= level_next;
      end
    end
  end

  assign o_accept    = accept_q & ~i_flush;
  assign o_valid     = not_empty;
  assign o_data      = not_empty ? mem[rd_ptr] : '0;
  assign o_level     = level;
  assign o_max_level = max_level;

endmodule

// File: tb/tb_x_tx_fifo.sv
// Testbench for x_tx_fifo: directed scenarios plus random traffic, checked
// against a queue-based reference model by a negedge monitor.
module tb_x_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       i_flush;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_accept;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_accept;
  logic [4:0] o_level;
  logic [4:0] o_max_level;

  int total = 0;
  int bad   = 0;

  x_tx_fifo #(.p_width(8), .p_depth(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_accept    (o_accept),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_accept    (i_accept),
    .o_level     (o_level),
    .o_max_level (o_max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a peak count and the registered accept flag.
  logic [7:0] mq[$];
  int         max_m;
  bit         acc_m;
  bit         m_push;
  bit         m_pop;
  logic [7:0] m_junk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      max_m = 0;
      acc_m = 1'b0;
    end else begin
      m_push = i_valid && acc_m && !i_flush;
      m_pop  = (mq.size() != 0) && i_accept && !i_flush;
      if (i_flush) begin
        mq.delete();
        max_m = 0;
      end else begin
        if (m_pop) m_junk = mq.pop_front();
        if (m_push) mq.push_back(i_data);
        if (mq.size() > max_m) max_m = mq.size();
      end
      acc_m = (mq.size() < DEPTH);
    end
  end

  // Monitor: compare every visible output against the model away from the edge.
  always @(negedge clk) begin
    chk("mon_level", int'(o_level), mq.size());
    chk("mon_max", int'(o_max_level), max_m);
    chk("mon_valid", int'(o_valid), (mq.size() != 0) ? 1 : 0);
    chk("mon_accept", int'(o_accept), (acc_m && !i_flush) ? 1 : 0);
    if (mq.size() != 0) chk("mon_head", int'(o_data), int'(mq[0]));
    else                chk("mon_data_idle", int'(o_data), 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    i_valid = 1'b1;
    i_data  = 8'hA5;
    i_accept = 1'b0;
    i_flush = 1'b0;
    rst_n   = 1'b0;
    repeat (3) step();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_accept", int'(o_accept), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_max", int'(o_max_level), 0);
    chk("rst_data", int'(o_data), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_accept_before_edge", int'(o_accept), 0);
    i_valid = 1'b0;
    step();
    chk("rel_accept_after_edge", int'(o_accept), 1);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = 8'(base + i);
      step();
    end
    i_valid = 1'b0;
  endtask

  task automatic flush1();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
  endtask

  int d;
  int h;

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; i_accept = 1'b0;

    // 1: reset behaviour
    reset_seq();

    // 2: single byte
    i_accept = 1'b0;
    push_n(1, 8'h3C);
    chk("s2_valid", int'(o_valid), 1);
    chk("s2_data", int'(o_data), 8'h3C);
    chk("s2_level", int'(o_level), 1);
    i_accept = 1'b1;
    step();
    i_accept = 1'b0;
    chk("s2_valid_after_pop", int'(o_valid), 0);
    chk("s2_level_after_pop", int'(o_level), 0);

    // 3: fill to full, drop an extra byte, drain in order
    push_n(16, 0);
    chk("s3_level_full", int'(o_level), 16);
    chk("s3_accept_full", int'(o_accept), 0);
    chk("s3_max_full", int'(o_max_level), 16);
    push_n(1, 8'hFF);
    chk("s3_level_after_drop", int'(o_level), 16);
    i_accept = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("s3_drain_data", int'(o_data), i);
      step();
    end
    i_accept = 1'b0;
    chk("s3_level_drained", int'(o_level), 0);
    chk("s3_valid_drained", int'(o_valid), 0);

    // 4: steady level 8 with simultaneous push/pop across pointer wrap
    flush1();
    push_n(8, 0);
    d = 8; h = 0;
    for (int i = 0; i < 40; i++) begin
      i_valid = 1'b1; i_accept = 1'b1; i_data = 8'(d); d++;
      chk("s4_head", int'(o_data), h); h++;
      step();
      chk("s4_level", int'(o_level), 8);
    end
    i_valid = 1'b0; i_accept = 1'b0;
    chk("s4_max", int'(o_max_level), 8);
    chk("s4_head_after", int'(o_data), 40);

    // 5: flush at level 5 with both handshakes active
    flush1();
    push_n(5, 8'h10);
    chk("s5_level_pre", int'(o_level), 5);
    i_flush = 1'b1; i_valid = 1'b1; i_accept = 1'b1; i_data = 8'hEE;
    step();
    i_flush = 1'b0; i_valid = 1'b0; i_accept = 1'b0;
    chk("s5_level", int'(o_level), 0);
    chk("s5_valid", int'(o_valid), 0);
    chk("s5_max", int'(o_max_level), 0);
    push_n(1, 8'h77);
    chk("s5_next_out", int'(o_data), 8'h77);
    chk("s5_next_valid", int'(o_valid), 1);
    i_accept = 1'b1;
    step();
    i_accept = 1'b0;

    // 6: async reset mid-burst at level 9
    push_n(9, 8'h40);
    chk("s6_level_pre", int'(o_level), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", int'(o_valid), 0);
    chk("s6_async_accept", int'(o_accept), 0);
    chk("s6_async_level", int'(o_level), 0);
    chk("s6_async_max", int'(o_max_level), 0);
    chk("s6_async_data", int'(o_data), 0);
    step();
    reset_seq();

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      i_valid  = ($urandom_range(0, 3) != 0);
      i_accept = ($urandom_range(0, 2) == 0);
      i_data   = 8'($urandom);
      i_flush  = ($urandom_range(0, 99) == 0);
      step();
    end
    i_valid = 1'b0; i_flush = 1'b0;
    i_accept = 1'b1;
    repeat (DEPTH + 2) step();
    chk("end_level", int'(o_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
